// File: rtl/tdt_icg_en_ctrl_pkg.sv
// Shared definitions for the per-module clock-enable controller.
// Holds the controller state encoding and the default parameter values.
package tdt_icg_en_ctrl_pkg;

    localparam int unsigned IDLE_CNT_W_DEF = 4;
    localparam int unsigned WAKE_DLY_DEF   = 2;
    // Wake counter must hold WAKE_DLY values up to 15.
    localparam int unsigned WAKE_CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'b00,
        ST_REQ    = 2'b01,
        ST_GATED  = 2'b10,
        ST_WAKE   = 2'b11
    } icg_state_e;

endpackage

// File: rtl/tdt_icg_en_ctrl.sv
// Clock-enable controller placed directly upstream of a module's gated clock cell.
// Counts idle cycles, negotiates a gate request/acknowledge with the module, drops
// the enable once the module is quiescent and re-enables it on a wake event.
//
// Ports:
//   forever_cpuclk   free-running clock (never gated)
//   cpurst           asynchronous active-high reset
//   busy             module has outstanding work
//   wake_req         external wake request
//   cfg_gate_en      1 = automatic gating allowed, 0 = clock forced on
//   cfg_idle_thresh  idle cycles required before requesting the gate
//   gate_ack         module confirms quiescence (only looked at in REQ)
//   gate_req         request to the module to quiesce
//   clk_en           drives the ICG local_en input
//   clk_rdy          gated clock is running and settled
//   gated_st         high while the clock is gated
module tdt_icg_en_ctrl
    import tdt_icg_en_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CNT_W = IDLE_CNT_W_DEF,
    parameter int unsigned WAKE_DLY   = WAKE_DLY_DEF
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  busy,
    input  logic                  wake_req,
    input  logic                  cfg_gate_en,
    input  logic [IDLE_CNT_W-1:0] cfg_idle_thresh,
    input  logic                  gate_ack,
    output logic                  gate_req,
    output logic                  clk_en,
    output logic                  clk_rdy,
    output logic                  gated_st
);

    icg_state_e            state_q, state_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_inc;
    logic [IDLE_CNT_W-1:0] thresh_eff;
    logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic                  abort;
    logic                  clk_en_q, clk_rdy_q, gate_req_q, gated_st_q;

    always_comb begin
        // Any activity or disabling gating keeps (or brings back) the clock.
        abort        = busy | wake_req | ~cfg_gate_en;
        idle_cnt_inc = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + 1'b1;
        thresh_eff   = (cfg_idle_thresh == '0) ? IDLE_CNT_W'(1) : cfg_idle_thresh;

        state_d    = state_q;
        idle_cnt_d = '0;
        wake_cnt_d = wake_cnt_q;

        case (state_q)
            ST_ACTIVE: begin
                if (!abort) begin
                    idle_cnt_d = idle_cnt_inc;
                    if (idle_cnt_inc >= thresh_eff) begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Abort wins over a simultaneous acknowledge.
                if (abort) begin
                    state_d = ST_ACTIVE;
                end else if (gate_ack) begin
                    state_d = ST_GATED;
                end
            end
            ST_GATED: begin
                if (abort) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WAKE_CNT_W'(WAKE_DLY);
                end
            end
            ST_WAKE: begin
                // Wake sequence always runs to completion, inputs ignored.
                wake_cnt_d = wake_cnt_q - 1'b1;
                if (wake_cnt_q == WAKE_CNT_W'(1)) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q    <= ST_ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            clk_en_q   <= 1'b1;
            clk_rdy_q  <= 1'b1;
            gate_req_q <= 1'b0;
            gated_st_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            // Outputs are decoded from the next state and flopped so that
            // clk_en never glitches on a state-encoding transition.
            clk_en_q   <= (state_d != ST_GATED);
            clk_rdy_q  <= (state_d == ST_ACTIVE) || (state_d == ST_REQ);
            gate_req_q <= (state_d == ST_REQ);
            gated_st_q <= (state_d == ST_GATED);
        end
    end

    assign clk_en   = clk_en_q;
    assign clk_rdy  = clk_rdy_q;
    assign gate_req = gate_req_q;
    assign gated_st = gated_st_q;

endmodule

// File: tb/tb_tdt_icg_en_ctrl.sv
// Self-checking bench for tdt_icg_en_ctrl. Each clocked step runs a small
// behavioural model, pushes the expected outputs and pops them after the edge.
module tb_tdt_icg_en_ctrl;

    localparam int unsigned IDLE_CNT_W = 4;
    localparam int unsigned WAKE_DLY   = 2;

    localparam int M_ACTIVE = 0;
    localparam int M_REQ    = 1;
    localparam int M_GATED  = 2;
    localparam int M_WAKE   = 3;

    logic                  forever_cpuclk = 1'b0;
    logic                  cpurst;
    logic                  busy;
    logic                  wake_req;
    logic                  cfg_gate_en;
    logic [IDLE_CNT_W-1:0] cfg_idle_thresh;
    logic                  gate_ack;
    logic                  gate_req;
    logic                  clk_en;
    logic                  clk_rdy;
    logic                  gated_st;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int m_st;
    int m_idle;
    int m_wake_left;

    logic [3:0] exp_q[$];

    tdt_icg_en_ctrl #(
        .IDLE_CNT_W(IDLE_CNT_W),
        .WAKE_DLY  (WAKE_DLY)
    ) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .busy           (busy),
        .wake_req       (wake_req),
        .cfg_gate_en    (cfg_gate_en),
        .cfg_idle_thresh(cfg_idle_thresh),
        .gate_ack       (gate_ack),
        .gate_req       (gate_req),
        .clk_en         (clk_en),
        .clk_rdy        (clk_rdy),
        .gated_st       (gated_st)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st        = M_ACTIVE;
        m_idle      = 0;
        m_wake_left = 0;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    function automatic void model_step();
        bit active_in;
        int thr;
        active_in = busy || wake_req || !cfg_gate_en;
        thr = (cfg_idle_thresh == 0) ? 1 : int'(cfg_idle_thresh);
        if (m_st == M_ACTIVE) begin
            if (active_in) m_idle = 0;
            else begin
                if (m_idle < 15) m_idle = m_idle + 1;
                if (m_idle >= thr) m_st = M_REQ;
            end
        end else if (m_st == M_REQ) begin
            if (active_in) begin
                m_st   = M_ACTIVE;
                m_idle = 0;
            end else if (gate_ack) m_st = M_GATED;
        end else if (m_st == M_GATED) begin
            if (active_in) begin
                m_st        = M_WAKE;
                m_wake_left = WAKE_DLY;
            end
        end else begin
            m_wake_left = m_wake_left - 1;
            if (m_wake_left == 0) begin
                m_st   = M_ACTIVE;
                m_idle = 0;
            end
        end
    endfunction

    // {clk_en, clk_rdy, gate_req, gated_st}
    function automatic logic [3:0] model_outs();
        case (m_st)
            M_ACTIVE: return 4'b1100;
            M_REQ:    return 4'b1110;
            M_GATED:  return 4'b0001;
            default:  return 4'b1000;
        endcase
    endfunction

    task automatic step();
        logic [3:0] exp;
        model_step();
        exp_q.push_back(model_outs());
        @(posedge forever_cpuclk);
        #1;
        exp = exp_q.pop_front();
        check("outs", {clk_en, clk_rdy, gate_req, gated_st}, exp);
    endtask

    task automatic run_until_req(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!gate_req && n < limit);
    endtask

    task automatic run_until_rdy(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!clk_rdy && n < limit);
    endtask

    task automatic run_until_gated(input int limit);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!gated_st && n < limit);
        check("reach_gated", gated_st, 1'b1);
    endtask

    initial begin
        int n;
        int req_seen;

        cpurst          = 1'b1;
        busy            = 1'b1;
        wake_req        = 1'b0;
        cfg_gate_en     = 1'b1;
        cfg_idle_thresh = 4'd3;
        gate_ack        = 1'b1;
        model_reset();
        #1;
        check("rst_outs", {clk_en, clk_rdy, gate_req, gated_st}, 4'b1100);
        repeat (2) @(negedge forever_cpuclk);
        cpurst = 1'b0;

        // Busy module: clock held on.
        repeat (10) step();
        check("busy_gate_req", gate_req, 1'b0);

        // Idle with threshold 3: request after 3 edges, gated one later.
        busy = 1'b0;
        run_until_req(10, n);
        check("req_latency_thr3", n, 3);
        step();
        check("gated_clk_en", clk_en, 1'b0);
        check("gated_st", gated_st, 1'b1);

        // Wake pulse: clk_en on the next cycle, clk_rdy WAKE_DLY cycles later.
        gate_ack = 1'b0;
        wake_req = 1'b1;
        step();
        wake_req = 1'b0;
        check("wake_clk_en", clk_en, 1'b1);
        check("wake_clk_rdy", clk_rdy, 1'b0);
        run_until_rdy(10, n);
        check("rdy_latency", n, WAKE_DLY);

        // Abort in REQ has priority over a simultaneous acknowledge.
        run_until_req(10, n);
        check("req_latency_again", n, 3);
        busy     = 1'b1;
        gate_ack = 1'b1;
        step();
        check("abort_gate_req", gate_req, 1'b0);
        check("abort_clk_en", clk_en, 1'b1);
        busy     = 1'b0;
        gate_ack = 1'b0;
        run_until_req(10, n);
        check("idle_restart", n, 3);

        // Disabling gating while gated wakes the module and keeps it on.
        gate_ack = 1'b1;
        run_until_gated(5);
        cfg_gate_en = 1'b0;
        req_seen = 0;
        repeat (24) begin
            step();
            if (gate_req) req_seen++;
        end
        check("forced_on_req", req_seen, 0);
        check("forced_on_rdy", clk_rdy, 1'b1);

        // Randomised traffic with live threshold changes.
        repeat (300) begin
            busy        = ($urandom_range(0, 5) == 0);
            wake_req    = ($urandom_range(0, 15) == 0);
            cfg_gate_en = ($urandom_range(0, 9) != 0);
            gate_ack    = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 7) == 0) cfg_idle_thresh = 4'($urandom_range(0, 15));
            step();
        end

        // Asynchronous reset while gated restores the clock before any edge.
        busy            = 1'b0;
        wake_req        = 1'b0;
        cfg_gate_en     = 1'b1;
        gate_ack        = 1'b1;
        cfg_idle_thresh = 4'd1;
        run_until_gated(40);
        check("pre_rst_clk_en", clk_en, 1'b0);
        #2;
        cpurst = 1'b1;
        #1;
        check("async_rst_clk_en", clk_en, 1'b1);
        check("async_rst_clk_rdy", clk_rdy, 1'b1);
        check("async_rst_gated_st", gated_st, 1'b0);
        model_reset();
        exp_q.delete();
        @(negedge forever_cpuclk);
        cpurst = 1'b0;

        // Threshold 0 acts as 1.
        gate_ack        = 1'b0;
        cfg_idle_thresh = 4'd0;
        busy            = 1'b1;
        step();
        busy = 1'b0;
        run_until_req(10, n);
        check("req_latency_thr0", n, 1);

        // Acknowledge ignored outside REQ; request held with no timeout.
        repeat (20) step();
        check("req_no_timeout", gate_req, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdt_icg_en_ctrl.md
Name: tdt_icg_en_ctrl

Overview:
- Per-module clock-enable controller sitting directly upstream of the gated clock cell; drives its local_en input.
- Watches module activity, counts idle cycles and negotiates a gate request/acknowledge with the module before dropping the enable.
- Re-enables the clock on a wake event and reports when the clock is usable again.
- One instance per gateable module; runs on the ungated (forever) clock.

Parameters:
IDLE_CNT_W, 4, width of idle counter and cfg_idle_thresh
WAKE_DLY, 2, cycles from clk_en reassertion to clk_rdy (1..15)

Ports:
forever_cpuclk  input  1  free-running clock, never gated
cpurst  input  1  asynchronous, active-high reset
busy  input  1  module has outstanding work (level)
wake_req  input  1  external wake request (level)
cfg_gate_en  input  1  1 = automatic gating allowed; 0 = clock forced on
cfg_idle_thresh  input  IDLE_CNT_W  idle cycles required before requesting gate
gate_ack  input  1  module confirms quiescence (level, sampled only in REQ)
gate_req  output  1  request to module to quiesce
clk_en  output  1  feeds ICG local_en
clk_rdy  output  1  gated clock is running and settled
gated_st  output  1  status: 1 while in GATED

Behaviour:
- All outputs and state are registered. Async reset gives state=ACTIVE, idle_cnt=0, wake_cnt=0, clk_en=1, clk_rdy=1, gate_req=0, gated_st=0.
- wake = busy | wake_req.
- State ACTIVE: clk_en=1, clk_rdy=1.
  - idle_cnt clears to 0 when wake=1 or cfg_gate_en=0.
  - Otherwise idle_cnt increments, saturating at all-ones.
  - Effective threshold = max(cfg_idle_thresh, 1).
  - Go to REQ when cfg_gate_en=1, wake=0 and the next idle_cnt >= threshold.
  - With threshold=3 and busy falling at cycle t, gate_req rises at t+3.
- State REQ: gate_req=1, clk_en=1, clk_rdy=1.
  - wake=1 or cfg_gate_en=0: back to ACTIVE with idle_cnt=0. Abort has priority over a simultaneous gate_ack.
  - Otherwise gate_ack=1: go to GATED.
  - Otherwise stay in REQ; there is no timeout.
- State GATED: clk_en=0, clk_rdy=0, gate_req=0, gated_st=1.
  - wake=1 or cfg_gate_en=0: go to WAKE, load wake_cnt=WAKE_DLY.
  - clk_en returns to 1 in the cycle after the wake is sampled.
- State WAKE: clk_en=1, clk_rdy=0, gated_st=0.
  - wake_cnt decrements each cycle.
  - When wake_cnt reaches 1, the next state is ACTIVE with idle_cnt=0.
  - Wake at cycle t in GATED gives clk_en=1 at t+1 and clk_rdy=1 at t+1+WAKE_DLY.
  - busy/wake_req changes inside WAKE are ignored; the wake sequence always completes.
- cfg_idle_thresh is sampled live each cycle. A change mid-count takes effect immediately, compared against the current idle_cnt.
- gate_ack outside REQ has no effect.
- Reset asserted mid-operation, in any state, forces ACTIVE with clk_en=1 asynchronously. A module is never left without a clock across reset.
- clk_en is glitch-free by construction (flop output). The ICG latch handles the timing relative to the clock edge.

Decomposition:
- Shared package holds:
  - state encoding constants ST_ACTIVE=2'b00, ST_REQ=2'b01, ST_GATED=2'b10, ST_WAKE=2'b11;
  - defaults for IDLE_CNT_W and WAKE_DLY.
- No sub-module is needed.
- The next-level wrapper pairs this block with the gated clock cell, which takes clk_en as local_en, global_en=1, module_en=0, external_en=0.

Test Plan:
- Reset release, busy=1, cfg_gate_en=1: clk_en=1, clk_rdy=1, gate_req=0 held indefinitely.
- thresh=3, busy drops at t, gate_ack=1 tied: gate_req=1 at t+3, GATED at t+4, clk_en=0 and gated_st=1 at t+4.
- GATED, wake_req pulse at t, WAKE_DLY=2: clk_en=1 at t+1, clk_rdy=0 at t+1 and t+2, clk_rdy=1 at t+3, idle_cnt=0.
- In REQ, busy=1 and gate_ack=1 in the same cycle: next state ACTIVE, gate_req=0, clk_en stays 1, idle count restarts.
- cfg_gate_en=0 while GATED: enters WAKE, then ACTIVE. Idle for 20 cycles afterwards: gate_req never asserts.
- Reset asserted asynchronously mid-GATED (clk_en=0): clk_en=1 and clk_rdy=1 immediately, before the next clock edge. thresh=0 behaves as thresh=1 (gate_req one cycle after idle).
